// File: rtl/fetch_unit_if.sv
// Instruction-memory read channel between fetch_unit and instruction memory.
// mem_req/mem_addr come from fetch; mem_ack/mem_rdata come back from memory.
interface fetch_unit_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC and runs one req/ack read per FETCH visit.
// Stalls the FDE state machine through fdm_en until the instruction is latched.
module fetch_unit #(
    parameter int                ADDR_W   = 16,
    parameter int                DATA_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        state,
    input  logic              br_take,
    input  logic [ADDR_W-1:0] br_target,
    fetch_unit_if.master      mem,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] pc,
    output logic              fdm_en
);
    localparam logic [1:0] ST_FETCH = 2'b00;
    localparam logic [1:0] ST_EXEC  = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_DONE = 2'b10
    } fsm_t;

    fsm_t              r_fsm;
    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_instr;
    logic              r_valid;
    logic              r_req;

    logic              w_fetch;
    logic              w_branch;

    assign w_fetch  = (state == ST_FETCH);
    assign w_branch = (state == ST_EXEC) && br_take;

    assign mem.mem_req  = r_req;
    assign mem.mem_addr = r_pc;
    assign pc           = r_pc;
    assign instr        = r_instr;
    assign instr_valid  = r_valid;
    assign fdm_en       = !w_fetch || (r_fsm == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm   <= S_IDLE;
            r_pc    <= RESET_PC;
            r_instr <= '0;
            r_valid <= 1'b0;
            r_req   <= 1'b0;
        end else begin
            case (r_fsm)
                S_IDLE: begin
                    if (w_fetch) begin
                        r_fsm   <= S_REQ;
                        r_req   <= 1'b1;
                        r_valid <= 1'b0;
                    end
                end
                S_REQ: begin
                    if (mem.mem_ack) begin
                        r_fsm   <= S_DONE;
                        r_req   <= 1'b0;
                        r_instr <= mem.mem_rdata;
                        r_valid <= 1'b1;
                        r_pc    <= r_pc + 1'b1;
                    end
                end
                S_DONE: begin
                    if (!w_fetch) r_fsm <= S_IDLE;
                end
                default: r_fsm <= S_IDLE;
            endcase
            // Redirect wins over any increment made on the same edge.
            if (w_branch) r_pc <= br_target;
        end
    end
endmodule
